// File: rtl/id_ex_ctrl_pipe_pkg.sv
// Shared opcode/funct constants, ALU op encoding and the EX control bundle
// for the MIPS-subset IF/ID -> ID/EX control pipeline.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  // Opcodes whose rt field is read as a source operand (not a destination).
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// Fetch-side and EX-side handshake/bundle signals of the ID control pipeline.
// The pipeline uses the slave modport; the environment drives the master side.
interface id_ex_ctrl_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             if_valid_i;
  logic [XLEN-1:0]  if_instr_i;
  logic             if_ready_o;
  logic             flush_i;
  logic             ex_ready_i;
  logic             ex_valid_o;
  logic [2:0]       ex_alu_op_o;
  logic             ex_reg_dst_o;
  logic             ex_reg_write_o;
  logic             ex_alu_src_o;
  logic             ex_mem_read_o;
  logic             ex_mem_write_o;
  logic             ex_mem_to_reg_o;
  logic             ex_branch_o;
  logic             ex_branch_ne_o;
  logic             ex_jump_o;
  logic [RA_W-1:0]  ex_rs_o;
  logic [RA_W-1:0]  ex_rt_o;
  logic [RA_W-1:0]  ex_wr_reg_o;
  logic [XLEN-1:0]  ex_imm_o;
  logic [25:0]      ex_jidx_o;
  logic             illegal_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output if_valid_i, if_instr_i, flush_i, ex_ready_i,
    input  if_ready_o, ex_valid_o, ex_alu_op_o, ex_reg_dst_o, ex_reg_write_o,
           ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
           ex_branch_o, ex_branch_ne_o, ex_jump_o, ex_rs_o, ex_rt_o,
           ex_wr_reg_o, ex_imm_o, ex_jidx_o, illegal_o, stall_cnt_o
  );

  modport slave (
    input  if_valid_i, if_instr_i, flush_i, ex_ready_i,
    output if_ready_o, ex_valid_o, ex_alu_op_o, ex_reg_dst_o, ex_reg_write_o,
           ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
           ex_branch_o, ex_branch_ne_o, ex_jump_o, ex_rs_o, ex_rt_o,
           ex_wr_reg_o, ex_imm_o, ex_jidx_o, illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_ctrl_pipe_decode.sv
// Purely combinational decode of one 32-bit MIPS-subset instruction into the
// EX control bundle, register indices and extended immediate.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [RA_W-1:0] rs,
  output logic [RA_W-1:0] rt,
  output logic [RA_W-1:0] wr_reg,
  output logic [XLEN-1:0] imm,
  output logic [25:0]     jidx,
  output logic            rt_src
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign rs     = RA_W'(instr[25:21]);
  assign rt     = RA_W'(instr[20:16]);
  assign jidx   = instr[25:0];
  assign rt_src = op_reads_rt(op);
  assign wr_reg = ctrl.reg_dst ? RA_W'(instr[15:11]) : RA_W'(instr[20:16]);

  // Logical immediates are zero-extended; everything else is sign-extended.
  assign imm = ((op == OP_ANDI) || (op == OP_ORI)) ? XLEN'(instr[15:0])
                                                   : XLEN'($signed(instr[15:0]));

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        // The all-zero word is the canonical NOP and is not flagged.
        if (instr != 32'h0) begin
          case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
              ctrl.alu_op    = ALU_RTYPE;
              ctrl.reg_dst   = 1'b1;
              ctrl.reg_write = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
          endcase
        end
      end
      OP_LW: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        case (op)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_J:    ctrl.jump    = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// IF/ID instruction register plus ID/EX control register with valid/ready
// back-pressure, flush and (when ID_HAZARD_DETECT_EN is defined) load-use bubbles.
module id_ex_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_ctrl_pipe_if.slave  bus
);

  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;

  logic             ex_valid_q, ex_valid_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0]  ex_rs_q, ex_rs_d;
  logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
  logic [RA_W-1:0]  ex_wr_q, ex_wr_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [25:0]      ex_jidx_q, ex_jidx_d;
  logic             ex_first_q, ex_first_d;

  ctrl_t            dec_ctrl;
  logic [RA_W-1:0]  dec_rs, dec_rt, dec_wr;
  logic [XLEN-1:0]  dec_imm;
  logic [25:0]      dec_jidx;
  logic             dec_rt_src;

  logic             ex_free;
  logic             hazard;
  logic             ifid_adv;
  logic             if_ready;

  ctrl_decode #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_decode (
    .instr  (ifid_instr_q),
    .ctrl   (dec_ctrl),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .wr_reg (dec_wr),
    .imm    (dec_imm),
    .jidx   (dec_jidx),
    .rt_src (dec_rt_src)
  );

  assign ex_free  = !ex_valid_q || bus.ex_ready_i;
  assign ifid_adv = ex_free && !hazard;
  assign if_ready = !ifid_valid_q || ifid_adv;

`ifdef ID_HAZARD_DETECT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A load writing a register the instruction in IF/ID reads cannot forward in time.
  assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_wr_q != '0) && ifid_valid_q &&
                  ((ex_wr_q == dec_rs) || (dec_rt_src && (ex_wr_q == dec_rt)));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.flush_i && ex_free && hazard && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  logic unused_rt_src;

  assign hazard          = 1'b0;
  assign unused_rt_src   = dec_rt_src;
  assign bus.stall_cnt_o = '0;
`endif

  // IF/ID stage boundary
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    if (bus.flush_i) begin
      ifid_valid_d = 1'b0;
    end else if (if_ready) begin
      ifid_valid_d = bus.if_valid_i;
      if (bus.if_valid_i) ifid_instr_d = bus.if_instr_i[31:0];
    end
  end

  // ID/EX stage boundary: advance, bubble, or hold
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_wr_d    = ex_wr_q;
    ex_imm_d   = ex_imm_q;
    ex_jidx_d  = ex_jidx_q;
    ex_first_d = 1'b0;
    if (bus.flush_i || (ex_free && !(ifid_adv && ifid_valid_q))) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_wr_d    = '0;
      ex_imm_d   = '0;
      ex_jidx_d  = '0;
    end else if (ifid_adv) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = dec_ctrl;
      ex_rs_d    = dec_rs;
      ex_rt_d    = dec_rt;
      ex_wr_d    = dec_wr;
      ex_imm_d   = dec_imm;
      ex_jidx_d  = dec_jidx;
      ex_first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_wr_q      <= '0;
      ex_imm_q     <= '0;
      ex_jidx_q    <= '0;
      ex_first_q   <= 1'b0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_wr_q      <= ex_wr_d;
      ex_imm_q     <= ex_imm_d;
      ex_jidx_q    <= ex_jidx_d;
      ex_first_q   <= ex_first_d;
    end
  end

  assign bus.if_ready_o      = if_ready;
  assign bus.ex_valid_o      = ex_valid_q;
  assign bus.ex_alu_op_o     = ex_ctrl_q.alu_op;
  assign bus.ex_reg_dst_o    = ex_ctrl_q.reg_dst;
  assign bus.ex_reg_write_o  = ex_ctrl_q.reg_write;
  assign bus.ex_alu_src_o    = ex_ctrl_q.alu_src;
  assign bus.ex_mem_read_o   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write_o  = ex_ctrl_q.mem_write;
  assign bus.ex_mem_to_reg_o = ex_ctrl_q.mem_to_reg;
  assign bus.ex_branch_o     = ex_ctrl_q.branch;
  assign bus.ex_branch_ne_o  = ex_ctrl_q.branch_ne;
  assign bus.ex_jump_o       = ex_ctrl_q.jump;
  assign bus.ex_rs_o         = ex_rs_q;
  assign bus.ex_rt_o         = ex_rt_q;
  assign bus.ex_wr_reg_o     = ex_wr_q;
  assign bus.ex_imm_o        = ex_imm_q;
  assign bus.ex_jidx_o       = ex_jidx_q;
  // Pulse only on the first cycle an illegal instruction sits valid in ID/EX.
  assign bus.illegal_o       = ex_valid_q && ex_first_q && ex_ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Scoreboard bench for id_ex_ctrl_pipe: decoded bundles are predicted when an
// instruction is accepted and compared when EX takes them.
module tb_id_ex_ctrl_pipe;

`ifdef ID_HAZARD_DETECT_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [31:0] imm;
    logic [25:0] jidx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];

  id_ex_ctrl_pipe_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();

  id_ex_ctrl_pipe #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bits: alu_op[2:0], reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op;
    op     = ins[31:26];
    e.ctrl = 12'b0;
    e.rs   = ins[25:21];
    e.rt   = ins[20:16];
    e.wr   = ins[20:16];
    e.jidx = ins[25:0];
    e.imm  = {{16{ins[15]}}, ins[15:0]};
    case (op)
      6'h00: if (ins != 32'h0 && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22 || ins[5:0] == 6'h24 ||
                                  ins[5:0] == 6'h25 || ins[5:0] == 6'h2A)) begin
               e.ctrl = 12'b010_1_1_0_0_0_0_0_0_0;
               e.wr   = ins[15:11];
             end
      6'h23: e.ctrl = 12'b000_0_1_1_1_0_1_0_0_0;
      6'h2B: e.ctrl = 12'b000_0_0_1_0_1_0_0_0_0;
      6'h04: e.ctrl = 12'b001_0_0_0_0_0_0_1_0_0;
      6'h05: e.ctrl = 12'b001_0_0_0_0_0_0_1_1_0;
      6'h08: e.ctrl = 12'b000_0_1_1_0_0_0_0_0_0;
      6'h0C: begin e.ctrl = 12'b011_0_1_1_0_0_0_0_0_0; e.imm = {16'h0, ins[15:0]}; end
      6'h0D: begin e.ctrl = 12'b100_0_1_1_0_0_0_0_0_0; e.imm = {16'h0, ins[15:0]}; end
      6'h0A: e.ctrl = 12'b111_0_1_1_0_0_0_0_0_0;
      6'h02: e.ctrl = 12'b000_0_0_0_0_0_0_0_0_1;
      default: e.ctrl = 12'b0;
    endcase
    return e;
  endfunction

  function automatic logic [11:0] ex_word();
    return {bus.ex_alu_op_o, bus.ex_reg_dst_o, bus.ex_reg_write_o, bus.ex_alu_src_o,
            bus.ex_mem_read_o, bus.ex_mem_write_o, bus.ex_mem_to_reg_o,
            bus.ex_branch_o, bus.ex_branch_ne_o, bus.ex_jump_o};
  endfunction

  // Drive one cycle from a falling edge, account for the coming rising edge, return at the next falling edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    exp_t e;
    bus.if_valid_i = v;
    bus.if_instr_i = ins;
    bus.ex_ready_i = rdy;
    bus.flush_i    = fl;
    #1;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (bus.ex_valid_o && rdy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 64'(bus.ex_valid_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ctrl", 64'(ex_word()), 64'(e.ctrl));
          chk("rs", 64'(bus.ex_rs_o), 64'(e.rs));
          chk("rt", 64'(bus.ex_rt_o), 64'(e.rt));
          chk("wr_reg", 64'(bus.ex_wr_reg_o), 64'(e.wr));
          chk("imm", 64'(bus.ex_imm_o), 64'(e.imm));
          chk("jidx", 64'(bus.ex_jidx_o), 64'(e.jidx));
        end
      end
      if (v && bus.if_ready_o) sb_q.push_back(model(ins));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [31:0] rtab [12];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rtab = '{32'h8C080004, 32'h01084820, 32'h20090001, 32'h3002FFFF, 32'h3404F00F,
             32'h2805FFFE, 32'hAC050008, 32'h10220003, 32'h14A6FFFC, 32'h08000010,
             32'h00A43022, 32'h0128502A};
    rst_n = 1'b0;
    bus.if_valid_i = 1'b0;
    bus.if_instr_i = 32'h0;
    bus.ex_ready_i = 1'b1;
    bus.flush_i    = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("rst_if_ready", 64'(bus.if_ready_o), 64'd1);
    chk("rst_stall", 64'(bus.stall_cnt_o), 64'd0);
    chk("rst_illegal", 64'(bus.illegal_o), 64'd0);
    chk("rst_ctrl", 64'(ex_word()), 64'd0);
    chk("rst_imm", 64'(bus.ex_imm_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back addi / andi
    cyc(1'b1, 32'h2001FFFF, 1'b1, 1'b0);
    cyc(1'b1, 32'h3002FFFF, 1'b1, 1'b0);
    chk("lat_first_valid", 64'(bus.ex_valid_o), 64'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("tput_second_valid", 64'(bus.ex_valid_o), 64'd1);
    drain();

    // lw $8 then add $9,$8,$8
    cyc(1'b1, 32'h8C080004, 1'b1, 1'b0);
    cyc(1'b1, 32'h01084820, 1'b1, 1'b0);
    chk("lu_stall_before", 64'(bus.stall_cnt_o), 64'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lu_bubble", 64'(bus.ex_valid_o), 64'(!HZ));
    chk("lu_stall_after", 64'(bus.stall_cnt_o), 64'(HZ));
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lu_add_arrives", 64'(bus.ex_valid_o), 64'(HZ));
    drain();

    // lw $8 then addi $9,$0,1: rt is a destination, no bubble
    cyc(1'b1, 32'h8C080004, 1'b1, 1'b0);
    cyc(1'b1, 32'h20090001, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("nolu_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("nolu_stall", 64'(bus.stall_cnt_o), 64'(HZ));
    drain();

    // EX back-pressure with both stages full
    cyc(1'b1, 32'h20030005, 1'b1, 1'b0);
    cyc(1'b1, 32'h34040F0F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h00A43022, 1'b0, 1'b0);
      chk("bp_if_ready", 64'(bus.if_ready_o), 64'd0);
      chk("bp_ex_valid", 64'(bus.ex_valid_o), 64'd1);
      chk("bp_hold_ctrl", 64'(ex_word()), 64'(sb_q[0].ctrl));
      chk("bp_hold_imm", 64'(bus.ex_imm_o), 64'(sb_q[0].imm));
    end
    cyc(1'b1, 32'h00A43022, 1'b1, 1'b0);
    drain();

    // Flush with both stages full and a new fetch offered
    cyc(1'b1, 32'h10220003, 1'b1, 1'b0);
    cyc(1'b1, 32'h08000010, 1'b1, 1'b0);
    cyc(1'b1, 32'hAC050008, 1'b1, 1'b1);
    chk("flush_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("flush_if_ready", 64'(bus.if_ready_o), 64'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_ifid_empty", 64'(bus.ex_valid_o), 64'd0);

    // Illegal opcode held in ID/EX for two cycles, then a NOP
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ill_pulse", 64'(bus.illegal_o), 64'd1);
    chk("ill_ctrl_zero", 64'(ex_word()), 64'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ill_one_cycle", 64'(bus.illegal_o), 64'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h00000000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("nop_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("nop_not_illegal", 64'(bus.illegal_o), 64'd0);
    drain();

    // Random stream with random fetch valid and EX ready
    for (int i = 0; i < 80; i++)
      cyc(($urandom % 4) != 0, rtab[$urandom % 12], ($urandom % 4) != 0, 1'b0);
    drain();

    // Reset mid-operation
    cyc(1'b1, 32'h8C080004, 1'b1, 1'b0);
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("midrst_illegal", 64'(bus.illegal_o), 64'd0);
    chk("midrst_stall", 64'(bus.stall_cnt_o), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("midrst_empty", 64'(bus.ex_valid_o), 64'd0);
    chk("midrst_if_ready", 64'(bus.if_ready_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_pipe.md
# id_ex_ctrl_pipe

Parametrised, pipelined successor to the single-cycle control decoder. Holds the IF/ID instruction register and the ID/EX control register, decodes the supported MIPS subset into EX-stage control bundles, and inserts load-use bubbles. It also honours flush requests from branch/jump resolution and applies valid/ready back-pressure in both directions. It sits between instruction fetch and the EX stage of the 5-stage core.

## Interface
Parameters:
- XLEN, 32, instruction/immediate width (≥32; instruction fields taken from bits 31:0)
- RA_W, 5, register-index width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_valid_i  in  1  fetch presents an instruction
- if_instr_i  in  XLEN  fetched instruction
- if_ready_o  out  1  IF/ID can accept this cycle
- flush_i  in  1  discard all in-flight instructions (branch taken / jump)
- ex_ready_i  in  1  EX accepts the ID/EX contents this cycle
- ex_valid_o  out  1  ID/EX holds a real instruction
- ex_alu_op_o  out  3  ALU operation code
- ex_reg_dst_o, ex_reg_write_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o, ex_branch_ne_o, ex_jump_o  out  1 each  control bits
- ex_rs_o, ex_rt_o, ex_wr_reg_o  out  RA_W  source indices; destination index (rd if reg_dst, else rt)
- ex_imm_o  out  XLEN  extended immediate
- ex_jidx_o  out  26  jump index field
- illegal_o  out  1  one-cycle pulse: unknown opcode/funct entered ID/EX
- stall_cnt_o  out  CNT_W  load-use bubbles inserted, saturating

## Operation
- Decode: R-type (funct add/sub/and/or/slt), lw, sw, beq, bne, addi, andi, ori, slti, j. Unlisted opcode/funct → all control bits 0, illegal flag set. Instruction 32'h0 → valid NOP, all controls 0, not illegal.
- No don't-cares: unused control bits drive 0.
- ALU op codes: ADD=000 (lw, sw, addi), SUB=001 (beq, bne), RTYPE=010, AND=011 (andi), OR=100 (ori), SLT=111 (slti).
- Immediate: andi/ori zero-extend imm16; all others sign-extend to XLEN.
- ex_branch_ne_o = 1 only for bne (ex_branch_o also 1).
- IF/ID capture when if_valid_i && if_ready_o; if_ready_o = !ifid_valid || ifid_adv.
- ex_free = !ex_valid_o || ex_ready_i; ifid_adv = ex_free && !hazard.
- ifid_adv: ID/EX loads decoded IF/ID contents, valid = ifid_valid.
- ex_free && hazard: ID/EX loads bubble (valid 0, controls 0), IF/ID holds, stall_cnt_o++ (saturates at all-ones).
- !ex_free: both registers hold.
- Hazard: ex_valid_o && ex_mem_read_o && ex_wr_reg_o≠0 && ifid_valid && (ex_wr_reg_o==ifid.rs || (ifid uses rt as source && ex_wr_reg_o==ifid.rt)). rt counts as a source for R-type, beq, bne, sw.
- flush_i: both valid bits cleared next edge; overrides capture, advance and hazard in the same cycle. stall_cnt_o unaffected.
- illegal_o asserted the cycle an illegal instruction is the valid ID/EX content on its first cycle there only.

## Timing
- Reset (async assert, sync-to-clk release): all valid 0, all ex_* outputs 0, illegal_o 0, stall_cnt_o 0; if_ready_o = 1.
- Latency: instruction accepted at edge N is on ex_* outputs after edge N+1 (no stall, ex_free).
- Throughput: 1 instr/cycle; each load-use adds exactly 1 bubble.
- if_ready_o and hazard are combinational from registered state plus ex_ready_i; no combinational path if_valid_i → if_ready_o.
- Reset mid-operation: in-flight instructions lost, no pulse emitted.

## Configuration
- ID_HAZARD_DETECT_EN defined: load-use detection and bubble insertion as above.
- Undefined: hazard tied 0; stall_cnt_o constant 0; the rest of the pipeline is unchanged and the compiler/software must schedule load delay slots.

## Structure
- Package mips_ctrl_pkg: opcode and funct constants, ALU op codes, packed ctrl_t struct (all control bits plus illegal).
- Sub-module ctrl_decode: purely combinational instr → ctrl_t, rs/rt/wr_reg/imm; instantiated once on IF/ID output.

## Test plan
- Reset, then stream 0x2001FFFF (addi $1,$0,-1), 0x3002FFFF (andi) back-to-back with ex_ready_i=1 → one per cycle; imm 0xFFFFFFFF alu_op 000 alu_src 1, then imm 0x0000FFFF alu_op 011.
- 0x8C080004 (lw $8) then 0x01084820 (add $9,$8,$8) → one bubble (ex_valid_o=0) between them; stall_cnt_o 0→1; add shows wr_reg 9, reg_dst 1, alu_op 010.
- lw $8 then addi $9,$0,1 (0x20090001) → no bubble (rt not a source).
- ex_ready_i=0 for 3 cycles with IF/ID and ID/EX full → ex_* outputs stable, if_ready_o=0, nothing lost after release.
- flush_i pulse with both stages full and if_valid_i=1 → next cycle ex_valid_o=0, IF/ID empty, if_ready_o=1.
- 0xFC000000 → illegal_o high exactly 1 cycle, all controls 0; 0x00000000 → valid NOP, illegal_o 0.
